// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receive stage. Oversamples the RX pin with the system
// clock, validates the start bit at its midpoint and samples each data bit and
// the stop bit mid-bit. The result is the byte and status bits that the
// UART register block exposes to the CPU through its data and status
// registers.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (even, >= 4)
//   DATA_WIDTH    payload bits per frame (>= 2)
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   rx_serial_in      asynchronous serial line, idle high
//   rx_data_read      1-cycle pulse: CPU read the data register
//   rx_error_clear    1-cycle pulse: clear both sticky error flags
//   rx_data           last good received byte
//   rx_data_ready     rx_data holds an unread byte
//   rx_frame_error    sticky: a stop bit was sampled low
//   rx_overrun_error  sticky: a good byte was dropped because ready was set
//   rx_busy           receiver is anywhere but idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_serial_in,
  input  logic                  rx_data_read,
  input  logic                  rx_error_clear,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_data_ready,
  output logic                  rx_frame_error,
  output logic                  rx_overrun_error,
  output logic                  rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_UART_RX_IDLE           = 2'd0,
    S_UART_RX_VALIDATE_START = 2'd1,
    S_UART_RX_READ_DATA      = 2'd2,
    S_UART_RX_STOP           = 2'd3
  } uart_fsm_state_t;

  // Registered state
  logic                  r_sync_meta;
  logic                  r_sync;
  uart_fsm_state_t       r_state;
  logic [CNT_W-1:0]      r_cycle_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  // Set while parked in STOP after a low stop bit, waiting for the line to
  // return high (break). The stop sample is not taken again in this mode.
  logic                  r_break;

  // Next-state / control from the combinational process
  logic                  w_rxs;
  uart_fsm_state_t       w_state_next;
  logic [CNT_W-1:0]      w_cycle_next;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_break_next;
  logic                  w_load;
  logic                  w_overrun_set;
  logic                  w_frame_set;

  assign w_rxs   = r_sync;
  assign rx_busy = (r_state != S_UART_RX_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default would infer a latch.
    w_state_next  = r_state;
    w_cycle_next  = r_cycle_cnt;
    w_bit_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_break_next  = r_break;
    w_load        = 1'b0;
    w_overrun_set = 1'b0;
    w_frame_set   = 1'b0;

    unique case (r_state)
      S_UART_RX_IDLE: begin
        if (!w_rxs) begin
          w_state_next = S_UART_RX_VALIDATE_START;
          w_cycle_next = '0;
        end
      end

      S_UART_RX_VALIDATE_START: begin
        if (r_cycle_cnt == HALF_LAST) begin
          if (!w_rxs) begin
            w_state_next = S_UART_RX_READ_DATA;
            w_cycle_next = '0;
            w_bit_next   = '0;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            w_state_next = S_UART_RX_IDLE;
          end
        end else begin
          w_cycle_next = r_cycle_cnt + 1'b1;
        end
      end

      S_UART_RX_READ_DATA: begin
        if (r_cycle_cnt == FULL_LAST) begin
          // LSB arrives first, so shift right and insert at the MSB.
          w_shift_next = {w_rxs, r_shift[DATA_WIDTH-1:1]};
          w_cycle_next = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_next = S_UART_RX_STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_cycle_next = r_cycle_cnt + 1'b1;
        end
      end

      S_UART_RX_STOP: begin
        if (r_break) begin
          if (w_rxs) begin
            w_state_next = S_UART_RX_IDLE;
            w_break_next = 1'b0;
          end
        end else if (r_cycle_cnt == FULL_LAST) begin
          w_cycle_next = '0;
          if (w_rxs) begin
            w_state_next = S_UART_RX_IDLE;
            // A read in the same cycle frees the holding register, so the
            // new byte can replace the old one without an overrun.
            if (!rx_data_ready || rx_data_read) begin
              w_load = 1'b1;
            end else begin
              w_overrun_set = 1'b1;
            end
          end else begin
            w_frame_set  = 1'b1;
            w_break_next = 1'b1;
          end
        end else begin
          w_cycle_next = r_cycle_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = S_UART_RX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to the idle line level so reset release cannot
      // look like a start edge.
      r_sync_meta      <= 1'b1;
      r_sync           <= 1'b1;
      r_state          <= S_UART_RX_IDLE;
      r_cycle_cnt      <= '0;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_break          <= 1'b0;
      rx_data          <= '0;
      rx_data_ready    <= 1'b0;
      rx_frame_error   <= 1'b0;
      rx_overrun_error <= 1'b0;
    end else begin
      r_sync_meta <= rx_serial_in;
      r_sync      <= r_sync_meta;
      r_state     <= w_state_next;
      r_cycle_cnt <= w_cycle_next;
      r_bit_cnt   <= w_bit_next;
      r_shift     <= w_shift_next;
      r_break     <= w_break_next;

      if (w_load) begin
        rx_data       <= r_shift;
        rx_data_ready <= 1'b1;
      end else if (rx_data_read) begin
        rx_data_ready <= 1'b0;
      end

      // Set has priority over clear for both sticky flags.
      if (w_frame_set) begin
        rx_frame_error <= 1'b1;
      end else if (rx_error_clear) begin
        rx_frame_error <= 1'b0;
      end

      if (w_overrun_set) begin
        rx_overrun_error <= 1'b1;
      end else if (rx_error_clear) begin
        rx_overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed testbench for uart_receiver at CLKS_PER_BIT=16, DATA_WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_serial_in;
  logic          rx_data_read;
  logic          rx_error_clear;
  logic [DW-1:0] rx_data;
  logic          rx_data_ready;
  logic          rx_frame_error;
  logic          rx_overrun_error;
  logic          rx_busy;

  int checks = 0;
  int errors = 0;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_serial_in    (rx_serial_in),
    .rx_data_read    (rx_data_read),
    .rx_error_clear  (rx_error_clear),
    .rx_data         (rx_data),
    .rx_data_ready   (rx_data_ready),
    .rx_frame_error  (rx_frame_error),
    .rx_overrun_error(rx_overrun_error),
    .rx_busy         (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " data"},    32'(rx_data), 32'h0);
    check({tag, " ready"},   32'(rx_data_ready), 32'h0);
    check({tag, " frame"},   32'(rx_frame_error), 32'h0);
    check({tag, " overrun"}, 32'(rx_overrun_error), 32'h0);
    check({tag, " busy"},    32'(rx_busy), 32'h0);
  endtask

  // Called at a falling edge. Drives start, 8 data bits LSB first and the stop
  // bit, CPB cycles each. Step n is the n-th falling edge after the start bit
  // was driven; the synchronized start edge is acted on at rising edge 3, so
  // the stop sample happens at rising edge 3+8+16*9 = 155 and ready is first
  // visible at step 155.
  //   timing   : check ready edge and busy during the frame
  //   read_at  : step at which rx_data_read is driven high for one cycle
  //   reset_at : step at which reset is driven for one cycle; frame aborts
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit timing, input int read_at,
                            input int reset_at);
    logic [9:0] bits;
    bit         busy_ok;
    bits    = {stop_bit, d, 1'b0};
    busy_ok = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      rx_serial_in = bits[i / CPB];
      rx_data_read = (i == read_at);
      reset        = (i == reset_at);
      @(negedge clk);
      if (i == reset_at) begin
        reset        = 1'b0;
        rx_data_read = 1'b0;
        rx_serial_in = 1'b1;
        check_reset_values("mid-frame reset");
        return;
      end
      if (timing) begin
        if (i + 1 == 154) check("ready before stop sample", 32'(rx_data_ready), 32'h0);
        if (i + 1 == 155) check("ready after stop sample", 32'(rx_data_ready), 32'h1);
        if (i + 1 >= 3 && i + 1 <= 154 && rx_busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    rx_data_read = 1'b0;
    if (timing) check("busy throughout frame", 32'(busy_ok), 32'h1);
  endtask

  task automatic pulse_read();
    rx_data_read = 1'b1;
    @(negedge clk);
    rx_data_read = 1'b0;
  endtask

  task automatic pulse_error_clear();
    rx_error_clear = 1'b1;
    @(negedge clk);
    rx_error_clear = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    rx_serial_in   = 1'b1;
    rx_data_read   = 1'b0;
    rx_error_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: good frame 0xA5 with exact ready timing
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    check("A5 data",    32'(rx_data), 32'hA5);
    check("A5 frame",   32'(rx_frame_error), 32'h0);
    check("A5 overrun", 32'(rx_overrun_error), 32'h0);
    pulse_read();
    check("A5 ready cleared by read", 32'(rx_data_ready), 32'h0);

    // 2: 5-cycle low glitch is rejected at the start-bit midpoint
    rx_serial_in = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch validating", 32'(rx_busy), 32'h1);
    rx_serial_in = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch busy",    32'(rx_busy), 32'h0);
    check("glitch ready",   32'(rx_data_ready), 32'h0);
    check("glitch frame",   32'(rx_frame_error), 32'h0);
    check("glitch overrun", 32'(rx_overrun_error), 32'h0);
    check("glitch data",    32'(rx_data), 32'hA5);

    // 3: overrun
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    check("3C ready", 32'(rx_data_ready), 32'h1);
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    check("overrun data kept", 32'(rx_data), 32'h3C);
    check("overrun flag",      32'(rx_overrun_error), 32'h1);
    pulse_error_clear();
    check("overrun cleared",       32'(rx_overrun_error), 32'h0);
    check("ready kept over clear", 32'(rx_data_ready), 32'h1);
    pulse_read();
    check("ready cleared after overrun", 32'(rx_data_ready), 32'h0);

    // 4: frame error with break
    send_frame(8'h55, 1'b0, 1'b0, -1, -1);
    repeat (40) @(negedge clk);
    check("break frame err", 32'(rx_frame_error), 32'h1);
    check("break ready",     32'(rx_data_ready), 32'h0);
    check("break holds",     32'(rx_busy), 32'h1);
    check("break data kept", 32'(rx_data), 32'h3C);
    rx_serial_in = 1'b1;
    repeat (5) @(negedge clk);
    check("break released", 32'(rx_busy), 32'h0);
    send_frame(8'h12, 1'b1, 1'b0, -1, -1);
    check("12 data",             32'(rx_data), 32'h12);
    check("12 ready",            32'(rx_data_ready), 32'h1);
    check("frame err is sticky", 32'(rx_frame_error), 32'h1);
    pulse_read();
    pulse_error_clear();
    check("frame err cleared", 32'(rx_frame_error), 32'h0);

    // 5: read coincides with the stop sample of a new good byte
    send_frame(8'h01, 1'b1, 1'b0, -1, -1);
    check("01 data", 32'(rx_data), 32'h01);
    send_frame(8'h02, 1'b1, 1'b0, 154, -1);
    check("read+load data",    32'(rx_data), 32'h02);
    check("read+load ready",   32'(rx_data_ready), 32'h1);
    check("read+load overrun", 32'(rx_overrun_error), 32'h0);

    // 6: reset in the middle of bit 3 (steps 64..79), then 0xF0
    send_frame(8'h9B, 1'b1, 1'b0, -1, 70);
    repeat (20) @(negedge clk);
    check("post-reset idle", 32'(rx_busy), 32'h0);
    send_frame(8'hF0, 1'b1, 1'b0, -1, -1);
    check("F0 data",    32'(rx_data), 32'hF0);
    check("F0 ready",   32'(rx_data_ready), 32'h1);
    check("F0 frame",   32'(rx_frame_error), 32'h0);
    check("F0 overrun", 32'(rx_overrun_error), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
